// File: rtl/motor_ctrl_pkg.sv
// Shared motor-control definitions: ramp FSM state encoding, default speed
// word width and the saturating step function also used by the position ramp.
package motor_ctrl_pkg;

  localparam int SW_DEF = 8;
  localparam int SAT_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    SET,
    ACK,
    REL
  } rampState_e;

  // One step from cur toward goal, clamped at goal; one extra bit of headroom
  // keeps the sum from wrapping at the top of the word.
  function automatic logic [SAT_W-1:0] stepSat(input logic [SAT_W-1:0] cur,
                                               input logic [SAT_W-1:0] goal,
                                               input logic [SAT_W-1:0] step);
    logic [SAT_W:0]   sum;
    logic [SAT_W-1:0] diff;
    sum  = {1'b0, cur} + {1'b0, step};
    diff = cur - goal;
    if (goal > cur)
      stepSat = (sum > {1'b0, goal}) ? goal : sum[SAT_W-1:0];
    else
      stepSat = (step >= diff) ? goal : cur - step;
  endfunction

endpackage

// File: rtl/spd_ramp_tick.sv
// Ramp interval timer: counts while enabled and flags the terminal count
// every max(Div,1) cycles, restarting from zero on the tick or on Clr.
module spd_ramp_tick #(
  parameter int TW = 16
) (
  input  logic          Clk,
  input  logic          sCntClr,
  input  logic          Clr,
  input  logic          En,
  input  logic [TW-1:0] Div,
  output logic          Tc
);

  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic [TW-1:0] lastCnt;

  // A divide of zero behaves as a divide of one, ticking every cycle.
  assign lastCnt = (Div == '0) ? '0 : Div - TW'(1);
  assign Tc      = En && (timer_q == lastCnt);

  always_comb begin
    timer_d = timer_q;
    if (Clr)
      timer_d = '0;
    else if (En)
      timer_d = Tc ? '0 : timer_q + TW'(1);
  end

  always_ff @(posedge Clk or posedge sCntClr) begin
    if (sCntClr)
      timer_q <= '0;
    else
      timer_q <= timer_d;
  end

endmodule

// File: rtl/spd_ramp_gen.sv
// Speed ramp generator: steps SpeedCmd toward the goal once per interval and
// hands each value downstream over SpeedSet/SpeedSetDone. Option: SPDRAMP_ESTOP_EN.
module spd_ramp_gen
  import motor_ctrl_pkg::*;
#(
  parameter int SW = SW_DEF,
  parameter int TW = 16
) (
  input  logic          Clk,
  input  logic          sCntClr,
  input  logic          RunEn,
  input  logic [SW-1:0] TargetSpd,
  input  logic [SW-1:0] AccStep,
  input  logic [TW-1:0] RampDiv,
  input  logic          SpeedSetDone,
`ifdef SPDRAMP_ESTOP_EN
  input  logic          EStop,
  output logic          EStopLat,
`endif
  output logic [SW-1:0] SpeedCmd,
  output logic          SpeedSet,
  output logic [SW-1:0] CurSpd,
  output logic          Busy,
  output logic          AtSpeed
);

  rampState_e    state_q;
  logic [SW-1:0] speedCmd_q;
  logic          speedSet_q;
  logic [SW-1:0] curSpd_q;
  logic [SW-1:0] goal;
  logic [SW-1:0] step;
  logic [SW-1:0] nextSpd;
  logic          tickTc;

`ifdef SPDRAMP_ESTOP_EN
  logic          eStopLat_q;
  logic          eStopPend_q;

  assign goal     = (RunEn && !eStopLat_q) ? TargetSpd : '0;
  assign EStopLat = eStopLat_q;
`else
  assign goal     = RunEn ? TargetSpd : '0;
`endif

  assign step    = (AccStep == '0) ? SW'(1) : AccStep;
  assign nextSpd = SW'(stepSat(SAT_W'(curSpd_q), SAT_W'(goal), SAT_W'(step)));

  spd_ramp_tick #(.TW(TW)) uTick (
    .Clk     (Clk),
    .sCntClr (sCntClr),
    .Clr     (state_q != WAIT_TICK),
    .En      (state_q == WAIT_TICK),
    .Div     (RampDiv),
    .Tc      (tickTc)
  );

  // The goal is re-read at every tick, so a goal change during a handshake
  // only steers the next update rather than aborting the current one.
  always_ff @(posedge Clk or posedge sCntClr) begin
    if (sCntClr) begin
      state_q    <= IDLE;
      speedCmd_q <= '0;
      speedSet_q <= 1'b0;
      curSpd_q   <= '0;
`ifdef SPDRAMP_ESTOP_EN
      eStopLat_q  <= 1'b0;
      eStopPend_q <= 1'b0;
`endif
    end else begin
`ifdef SPDRAMP_ESTOP_EN
      if (EStop && !eStopLat_q && (state_q == IDLE || state_q == WAIT_TICK)) begin
        speedCmd_q  <= '0;
        speedSet_q  <= 1'b1;
        eStopPend_q <= 1'b1;
        state_q     <= SET;
      end else begin
        if (EStop && !eStopLat_q)
          eStopPend_q <= 1'b1;
`endif
      case (state_q)
        IDLE: begin
          if (goal != curSpd_q)
            state_q <= WAIT_TICK;
        end
        WAIT_TICK: begin
          if (tickTc) begin
            if (goal == curSpd_q) begin
              state_q <= IDLE;
            end else begin
              speedCmd_q <= nextSpd;
              speedSet_q <= 1'b1;
              state_q    <= SET;
            end
          end
        end
        SET: state_q <= ACK;
        ACK: begin
          if (SpeedSetDone) begin
            speedSet_q <= 1'b0;
            curSpd_q   <= speedCmd_q;
            state_q    <= REL;
          end
        end
        REL: begin
          if (!SpeedSetDone) begin
`ifdef SPDRAMP_ESTOP_EN
            // A stop requested mid-handshake is served once the downstream
            // has released; only a delivered zero latches the stop.
            if (eStopPend_q) begin
              if (curSpd_q == '0) begin
                eStopLat_q  <= 1'b1;
                eStopPend_q <= 1'b0;
                state_q     <= IDLE;
              end else begin
                speedCmd_q <= '0;
                speedSet_q <= 1'b1;
                state_q    <= SET;
              end
            end else
`endif
            state_q <= (goal == curSpd_q) ? IDLE : WAIT_TICK;
          end
        end
        default: state_q <= IDLE;
      endcase
`ifdef SPDRAMP_ESTOP_EN
      end
      if (eStopLat_q && !RunEn && !EStop)
        eStopLat_q <= 1'b0;
`endif
    end
  end

  assign SpeedCmd = speedCmd_q;
  assign SpeedSet = speedSet_q;
  assign CurSpd   = curSpd_q;
  assign Busy     = (state_q != IDLE);
  assign AtSpeed  = (state_q == IDLE) && (curSpd_q == goal);

endmodule

// File: tb/tb_spd_ramp_gen.sv
// Directed bench for spd_ramp_gen: table of ramp profiles with expected strobe
// sequences, plus hand-written stall, reset-in-handshake and stop sequences.
module tb_spd_ramp_gen;

  logic        Clk = 1'b0;
  logic        sCntClr;
  logic        RunEn;
  logic [7:0]  TargetSpd;
  logic [7:0]  AccStep;
  logic [15:0] RampDiv;
  logic        SpeedSetDone;
  logic [7:0]  SpeedCmd;
  logic        SpeedSet;
  logic [7:0]  CurSpd;
  logic        Busy;
  logic        AtSpeed;
`ifdef SPDRAMP_ESTOP_EN
  logic        EStop;
  logic        EStopLat;
`endif

  logic        done1 = 1'b0;
  logic        done2 = 1'b0;
  logic        holdDone = 1'b0;
  logic        lastSet = 1'b0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  strobeVal[$];
  int          strobeCyc[$];

  typedef struct {
    logic        run;
    logic [7:0]  tgt;
    logic [7:0]  step;
    logic [15:0] div;
    int          n;
    logic [7:0]  exp[6];
    logic [7:0]  finalCur;
  } vec_t;

  vec_t vecs[8];

  spd_ramp_gen dut (
    .Clk          (Clk),
    .sCntClr      (sCntClr),
    .RunEn        (RunEn),
    .TargetSpd    (TargetSpd),
    .AccStep      (AccStep),
    .RampDiv      (RampDiv),
    .SpeedSetDone (SpeedSetDone),
`ifdef SPDRAMP_ESTOP_EN
    .EStop        (EStop),
    .EStopLat     (EStopLat),
`endif
    .SpeedCmd     (SpeedCmd),
    .SpeedSet     (SpeedSet),
    .CurSpd       (CurSpd),
    .Busy         (Busy),
    .AtSpeed      (AtSpeed)
  );

  always #5 Clk = ~Clk;

  // Downstream pulse generator: acknowledge is SpeedSet delayed two clocks.
  always @(posedge Clk) begin
    done1 <= SpeedSet;
    done2 <= done1;
    cyc   <= cyc + 1;
  end
  assign SpeedSetDone = done2 && !holdDone;

  always @(negedge Clk) begin
    if (SpeedSet && !lastSet) begin
      strobeVal.push_back(SpeedCmd);
      strobeCyc.push_back(cyc);
    end
    lastSet = SpeedSet;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic waitIdle(input string name);
    int budget = 0;
    while (Busy && budget < 3000) begin
      @(negedge Clk);
      budget++;
    end
    if (budget >= 3000) checkOutput({name, "_timeout"}, 1, 0);
  endtask

  task automatic applyStimulus(input string name, input vec_t v);
    int dv;
    int c0;
    int gap;
    dv = (v.div == 16'd0) ? 1 : int'(v.div);
    @(negedge Clk);
    strobeVal.delete();
    strobeCyc.delete();
    RunEn     = v.run;
    TargetSpd = v.tgt;
    AccStep   = v.step;
    RampDiv   = v.div;
    c0        = cyc;
    repeat (dv + 3) @(negedge Clk);
    waitIdle(name);
    checkOutput({name, "_count"}, strobeVal.size(), v.n);
    for (int i = 0; i < v.n && i < strobeVal.size(); i++)
      checkOutput($sformatf("%s_cmd%0d", name, i), int'(strobeVal[i]), int'(v.exp[i]));
    if (v.n > 0 && strobeCyc.size() > 0)
      checkOutput({name, "_latency"}, strobeCyc[0] - c0, dv + 1);
    for (int i = 1; i < strobeCyc.size(); i++) begin
      gap = strobeCyc[i] - strobeCyc[i-1];
      checkOutput($sformatf("%s_gap%0d_inwin", name, i),
                  int'(gap >= dv + 4 && gap <= dv + 7), 1);
    end
    checkOutput({name, "_curSpd"}, int'(CurSpd), int'(v.finalCur));
    checkOutput({name, "_atSpeed"}, int'(AtSpeed), 1);
    checkOutput({name, "_busy"}, int'(Busy), 0);
  endtask

  task automatic waitStrobe(input string name);
    int budget = 0;
    while (!SpeedSet && budget < 500) begin
      @(negedge Clk);
      budget++;
    end
    if (budget >= 500) checkOutput({name, "_timeout"}, 1, 0);
  endtask

  initial begin
    vec_t v;
    logic [7:0] cmd0;
    int ok;

    vecs[0] = '{1'b1, 8'd40,  8'd10,  16'd4, 4, '{8'd10, 8'd20, 8'd30, 8'd40, 8'd0, 8'd0}, 8'd40};
    vecs[1] = '{1'b0, 8'd40,  8'd15,  16'd4, 3, '{8'd25, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0}, 8'd0};
    vecs[2] = '{1'b1, 8'd45,  8'd10,  16'd4, 5, '{8'd10, 8'd20, 8'd30, 8'd40, 8'd45, 8'd0}, 8'd45};
    vecs[3] = '{1'b1, 8'd250, 8'd255, 16'd3, 1, '{8'd250, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 8'd250};
    vecs[4] = '{1'b1, 8'd250, 8'd10,  16'd4, 0, '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 8'd250};
    vecs[5] = '{1'b1, 8'd255, 8'd200, 16'd2, 1, '{8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 8'd255};
    vecs[6] = '{1'b0, 8'd255, 8'd255, 16'd2, 1, '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 8'd0};
    vecs[7] = '{1'b1, 8'd3,   8'd0,   16'd0, 3, '{8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0}, 8'd3};

    sCntClr = 1'b1;
    RunEn = 1'b0;
    TargetSpd = 8'd0;
    AccStep = 8'd1;
    RampDiv = 16'd1;
`ifdef SPDRAMP_ESTOP_EN
    EStop = 1'b0;
`endif
    repeat (3) @(negedge Clk);
    checkOutput("rst_speedCmd", int'(SpeedCmd), 0);
    checkOutput("rst_speedSet", int'(SpeedSet), 0);
    checkOutput("rst_curSpd", int'(CurSpd), 0);
    checkOutput("rst_busy", int'(Busy), 0);
    checkOutput("rst_atSpeed", int'(AtSpeed), 1);
    sCntClr = 1'b0;
    repeat (2) @(negedge Clk);

    for (int i = 0; i < 8; i++)
      applyStimulus($sformatf("vec%0d", i), vecs[i]);

    // Acknowledge withheld: the strobe and command must hold and no tick advances.
    holdDone = 1'b1;
    strobeVal.delete();
    strobeCyc.delete();
    RunEn = 1'b1; TargetSpd = 8'd20; AccStep = 8'd10; RampDiv = 16'd2;
    waitStrobe("stall");
    cmd0 = SpeedCmd;
    checkOutput("stall_cmd", int'(cmd0), 13);
    ok = 1;
    repeat (20) begin
      @(negedge Clk);
      if (!(SpeedSet && SpeedCmd == cmd0 && CurSpd == 8'd3 && Busy)) ok = 0;
    end
    checkOutput("stall_hold", ok, 1);
    checkOutput("stall_strobes", strobeVal.size(), 1);
    holdDone = 1'b0;
    repeat (3) @(negedge Clk);
    waitIdle("stall_done");
    checkOutput("stall_final", int'(CurSpd), 20);
    checkOutput("stall_strobes2", strobeVal.size(), 2);
    if (strobeVal.size() == 2) checkOutput("stall_cmd2", int'(strobeVal[1]), 20);

    // Reset asserted in the middle of a handshake.
    holdDone = 1'b1;
    RunEn = 1'b1; TargetSpd = 8'd40; AccStep = 8'd10; RampDiv = 16'd1;
    waitStrobe("rstack");
    repeat (3) @(negedge Clk);
    checkOutput("rstack_setHigh", int'(SpeedSet), 1);
    sCntClr = 1'b1;
    RunEn = 1'b0;
    #1;
    checkOutput("rstack_speedSet", int'(SpeedSet), 0);
    checkOutput("rstack_speedCmd", int'(SpeedCmd), 0);
    checkOutput("rstack_curSpd", int'(CurSpd), 0);
    checkOutput("rstack_busy", int'(Busy), 0);
    checkOutput("rstack_atSpeed", int'(AtSpeed), 1);
    repeat (2) @(negedge Clk);
    holdDone = 1'b0;
    sCntClr = 1'b0;
    v = '{1'b1, 8'd20, 8'd10, 16'd2, 2, '{8'd10, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0}, 8'd20};
    applyStimulus("postrst", v);

`ifdef SPDRAMP_ESTOP_EN
    v = '{1'b1, 8'd40, 8'd10, 16'd2, 2, '{8'd30, 8'd40, 8'd0, 8'd0, 8'd0, 8'd0}, 8'd40};
    applyStimulus("preStop", v);
    @(negedge Clk);
    EStop = 1'b1;
    repeat (3) @(negedge Clk);
    waitIdle("estop");
    checkOutput("estop_cmd", int'(SpeedCmd), 0);
    checkOutput("estop_cur", int'(CurSpd), 0);
    checkOutput("estop_lat", int'(EStopLat), 1);
    EStop = 1'b0;
    RunEn = 1'b0;
    repeat (2) @(negedge Clk);
    checkOutput("estop_latClr", int'(EStopLat), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
